// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: op codes, FSM states and flag bit
// positions. decode_op folds every reserved code onto OP_RSV so the datapath
// only ever sees legal enum values.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_NOT = 4'd5,
      OP_SHL = 4'd6,
      OP_SHR = 4'd7,
      OP_SRA = 4'd8,
      OP_MUL = 4'd9,
      OP_SLT = 4'd10,
      OP_RSV = 4'd15
   } op_e;

   typedef enum logic {
      RUN = 1'b0,
      MUL = 1'b1
   } state_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

   function automatic op_e decode_op(input logic [3:0] code);
      return (code <= 4'd10) ? op_e'(code) : OP_RSV;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq.
//   master : operand source + result consumer (drives in_valid/a/b/op/out_ready)
//   slave  : the ALU (drives in_ready/out_valid/y/hi/flags/illegal)
interface alu_seq_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] hi;
   logic [3:0]       flags;
   logic             illegal;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, y, hi, flags, illegal
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, y, hi, flags, illegal
   );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, rst   clock, async active-high reset
//   start      load a/b and begin; ignored bits of a running product are dropped
//   a, b       unsigned operands
//   done       high during the final step; product is valid in that cycle
//   product    2*WIDTH result (combinational view of the accumulator after
//              the current step, so the caller can register it on done)
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               busy_q;

   assign acc_next = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
   assign done     = busy_q && (cnt_q == LAST);
   assign product  = acc_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start) begin
         mcand_q  <= {{WIDTH{1'b0}}, a};
         acc_q    <= '0;
         mplier_q <= b;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (done) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
         end else begin
            cnt_q  <= cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-generic ALU with status flags, barrel shifts, signed
// compare and an iterative unsigned multiplier.
// Ports:
//   clk, rst   clock, async active-high reset
//   bus        alu_seq_if.slave: in_valid/in_ready/a/b/op in,
//              out_valid/out_ready/y/hi/flags/illegal out
// All result outputs are registered; in_ready depends only on state,
// out_valid, out_ready and rst.
//
// state | meaning
// RUN   | accepting ops; single-cycle results load the output registers
// MUL   | multiplier stepping; input port closed until the product lands
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);

   state_e             state_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   y_q;
   logic [WIDTH-1:0]   hi_q;
   logic [3:0]         flags_q;
   logic               illegal_q;

   op_e                op_dec;
   logic               in_ready;
   logic               in_fire;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   logic [SHW-1:0]     sh;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic signed [WIDTH:0] sra_ext;
   logic [WIDTH-1:0]   res_y;
   logic               res_c;
   logic               res_v;
   logic               res_ill;
   logic [3:0]         res_flags;
   logic [3:0]         mul_flags;

   assign op_dec    = decode_op(bus.op);
   assign in_ready  = (state_q == RUN) && (!out_valid_q || bus.out_ready) && !rst;
   assign in_fire   = bus.in_valid && in_ready;
   assign mul_start = in_fire && (op_dec == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (bus.a),
      .b       (bus.b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Shifts carry one guard bit so the last bit shifted out falls into a
   // known position; with a zero amount that bit is naturally 0.
   always_comb begin
      sh      = bus.b[SHW-1:0];
      sum     = {1'b0, bus.a} + {1'b0, bus.b};
      diff    = {1'b0, bus.a} - {1'b0, bus.b};
      shl_ext = {1'b0, bus.a} << sh;
      shr_ext = {bus.a, 1'b0} >> sh;
      sra_ext = $signed({bus.a, 1'b0}) >>> sh;
      res_y   = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_ill = 1'b0;
      case (op_dec)
         OP_ADD: begin
            res_y = sum[WIDTH-1:0];
            res_c = sum[WIDTH];
            res_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_SUB: begin
            res_y = diff[WIDTH-1:0];
            res_c = diff[WIDTH];
            res_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
         end
         OP_AND: res_y = bus.a & bus.b;
         OP_OR:  res_y = bus.a | bus.b;
         OP_XOR: res_y = bus.a ^ bus.b;
         OP_NOT: res_y = ~bus.a;
         OP_SHL: begin
            res_y = shl_ext[WIDTH-1:0];
            res_c = shl_ext[WIDTH];
         end
         OP_SHR: begin
            res_y = shr_ext[WIDTH:1];
            res_c = shr_ext[0];
         end
         OP_SRA: begin
            res_y = sra_ext[WIDTH:1];
            res_c = sra_ext[0];
         end
         OP_SLT: res_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_MUL: res_y = '0;
         default: res_ill = 1'b1;
      endcase

      res_flags         = '0;
      res_flags[FLAG_C] = res_c;
      res_flags[FLAG_Z] = !res_ill && (res_y == '0);
      res_flags[FLAG_N] = res_y[WIDTH-1];
      res_flags[FLAG_V] = res_v;

      mul_flags         = '0;
      mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
      mul_flags[FLAG_Z] = (mul_product == '0);
      mul_flags[FLAG_N] = mul_product[WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         out_valid_q <= 1'b0;
         y_q         <= '0;
         hi_q        <= '0;
         flags_q     <= '0;
         illegal_q   <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (in_fire) begin
                  if (op_dec == OP_MUL) begin
                     out_valid_q <= 1'b0;
                     state_q     <= MUL;
                  end else begin
                     y_q         <= res_y;
                     hi_q        <= '0;
                     flags_q     <= res_flags;
                     illegal_q   <= res_ill;
                     out_valid_q <= 1'b1;
                  end
               end else if (out_valid_q && bus.out_ready) begin
                  out_valid_q <= 1'b0;
               end
            end
            MUL: begin
               if (mul_done) begin
                  y_q         <= mul_product[WIDTH-1:0];
                  hi_q        <= mul_product[2*WIDTH-1:WIDTH];
                  flags_q     <= mul_flags;
                  illegal_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= RUN;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.y         = y_q;
   assign bus.hi        = hi_q;
   assign bus.flags     = flags_q;
   assign bus.illegal   = illegal_q;

endmodule
